// File: rtl/rx_word_align_sync.sv
// 8B/10B receive word aligner: comma search over a two-beat window, barrel shift
// onto the found boundary, and a loss-of-sync state machine fed by decoder errors.
module rx_word_align_sync #(
  parameter int NSYM = 2,
  parameter int PW   = 5,
  parameter int ERRW = 10,
  localparam int DW  = 10 * NSYM
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_En,
  input  logic [DW-1:0]   i_Data,
  input  logic [9:0]      i_MComma,
  input  logic [9:0]      i_PComma,
  input  logic [9:0]      i_CommaMask,
  input  logic            i_MComEn,
  input  logic            i_PComEn,
  input  logic            i_SlideMode,
  input  logic            i_Slide,
  input  logic [NSYM-1:0] i_DecErr,
  input  logic            i_MisalignChk,
  input  logic [1:0]      i_SyncThres,
  input  logic [2:0]      i_InvalidIncr,
  input  logic [2:0]      i_ErrThreshold,
  output logic [DW-1:0]   o_Data,
  output logic            o_Valid,
  output logic [NSYM-1:0] o_CommaFlag,
  output logic [PW-1:0]   o_AlignPos,
  output logic            o_Realign,
  output logic [1:0]      o_SyncState,
  output logic            o_SyncLock
);

  typedef enum logic [1:0] {
    LOS  = 2'b00,
    TEST = 2'b01,
    PRE  = 2'b10,
    SYNC = 2'b11
  } syncState_t;

  syncState_t        state, stateNext;
  logic [DW-1:0]     rPrev;
  logic [2*DW-1:0]   window;
  logic [DW-1:0]     commaHit, rComma;
  logic [DW-1:0]     alignedData;
  logic [NSYM-1:0]   laneFlag;
  logic [PW-1:0]     pos, posNext, firstIdx;
  logic [ERRW-1:0]   errCnt, errNext, goodCnt, goodNext, tstCnt, tstNext;
  logic [ERRW-1:0]   beatErr, errThr, tstTarget, decMask;
  logic [ERRW:0]     errSum;
  logic              slidePrev;

  function automatic logic commaMatch(input logic [9:0] sym, input logic [9:0] mPat,
                                      input logic [9:0] pPat, input logic [9:0] mask,
                                      input logic mEn, input logic pEn);
    return (mEn && (((sym ^ mPat) & mask) == 10'd0)) ||
           (pEn && (((sym ^ pPat) & mask) == 10'd0));
  endfunction

  // Comma search, barrel shift and per-beat error count.
  always_comb begin
    window   = {i_Data, rPrev};
    commaHit = '0;
    for (int k = 0; k < DW; k++)
      commaHit[k] = commaMatch(window[k +: 10], i_MComma, i_PComma, i_CommaMask, i_MComEn, i_PComEn);
    alignedData = DW'(window >> pos);
    laneFlag    = '0;
    for (int j = 0; j < NSYM; j++)
      laneFlag[j] = commaMatch(alignedData[10*j +: 10], i_MComma, i_PComma, i_CommaMask, i_MComEn, i_PComEn);
    firstIdx = '0;
    for (int k = DW - 1; k >= 0; k--)
      if (rComma[k]) firstIdx = PW'(k);
    beatErr = '0;
    for (int j = 0; j < NSYM; j++)
      beatErr = beatErr + ERRW'(i_DecErr[j]);
    // A comma that shows up anywhere but the locked offset counts as one extra error.
    if (state == SYNC && i_MisalignChk && rComma != '0 && !rComma[pos])
      beatErr = beatErr + ERRW'(1);
  end

  assign errThr    = ERRW'(4) << i_ErrThreshold;
  assign tstTarget = ERRW'(2) << i_SyncThres;
  assign decMask   = (ERRW'(2) << i_InvalidIncr) - ERRW'(1);
  assign errSum    = {1'b0, errCnt} + {1'b0, beatErr};

  // Next offset, sync state and good/error counters.
  always_comb begin
    stateNext = state;
    posNext   = pos;
    errNext   = errCnt;
    goodNext  = goodCnt;
    tstNext   = tstCnt;
    if (!i_En) begin
      stateNext = LOS;
      errNext   = '0;
      goodNext  = '0;
      tstNext   = '0;
    end else begin
      if (i_SlideMode) begin
        if (i_Slide && !slidePrev)
          posNext = (pos == PW'(DW - 1)) ? '0 : pos + PW'(1);
      end else if (state == LOS && rComma != '0) begin
        posNext = firstIdx;
      end
      case (state)
        LOS: begin
          errNext  = '0;
          goodNext = '0;
          tstNext  = '0;
          if (rComma != '0) stateNext = PRE;
        end
        PRE: begin
          errNext   = '0;
          goodNext  = '0;
          tstNext   = '0;
          stateNext = TEST;
        end
        TEST: begin
          errNext  = '0;
          goodNext = '0;
          if (beatErr != '0) begin
            stateNext = LOS;
            tstNext   = '0;
          end else begin
            tstNext = tstCnt + ERRW'(1);
            if (tstNext == tstTarget) begin
              stateNext = SYNC;
              tstNext   = '0;
            end
          end
        end
        SYNC: begin
          if (errCnt >= errThr) begin
            stateNext = LOS;
            errNext   = '0;
            goodNext  = '0;
          end else if (beatErr != '0) begin
            errNext = (errSum >= {1'b0, errThr}) ? errThr : errSum[ERRW-1:0];
          end else begin
            if ((goodCnt & decMask) == decMask && errCnt != '0)
              errNext = errCnt - ERRW'(1);
            goodNext = goodCnt + ERRW'(1);
          end
        end
        default: stateNext = LOS;
      endcase
    end
  end

  // Registered state and datapath; when disabled the raw beat passes straight through.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= LOS;
      pos         <= '0;
      errCnt      <= '0;
      goodCnt     <= '0;
      tstCnt      <= '0;
      slidePrev   <= 1'b0;
      rPrev       <= '0;
      rComma      <= '0;
      o_Data      <= '0;
      o_CommaFlag <= '0;
      o_Realign   <= 1'b0;
    end else begin
      state       <= stateNext;
      pos         <= posNext;
      errCnt      <= errNext;
      goodCnt     <= goodNext;
      tstCnt      <= tstNext;
      slidePrev   <= i_Slide;
      o_Realign   <= (posNext != pos);
      if (i_En) begin
        rPrev       <= i_Data;
        rComma      <= commaHit;
        o_Data      <= alignedData;
        o_CommaFlag <= laneFlag;
      end else begin
        rComma      <= '0;
        o_Data      <= i_Data;
        o_CommaFlag <= '0;
      end
    end
  end

  assign o_Valid     = (state == SYNC);
  assign o_SyncLock  = (state == SYNC);
  assign o_SyncState = state;
  assign o_AlignPos  = pos;

endmodule
